cnn_layer_sequencer: RTL and testbench

- Successor to the fixed six-layer LeNet geometry case-table. Each layer's geometry now comes from a runtime-loadable descriptor table of up to MAX_LAYERS entries, not a hard-coded table.
- Derives per-layer GEMM dimensions (M, Mij, N, K, padding_M, STRIDE) in registered pipeline stages.
- Drives the layerX compute engine with a start/done handshake.
- Adds abort, descriptor validation, and a network-done indication.

---
 rtl/cnn_seq_pkg.sv | 62 ++++++
 rtl/cnn_desc_ram.sv | 28 ++
 rtl/cnn_layer_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and geometry widths for the CNN layer sequencer.
// Field widths are derived from the MAX_* limits so every descriptor field
// and derived dimension is sized consistently across the design.
package cnn_seq_pkg;

  localparam int MAX_LAYERS = 8;
  localparam int MAX_X1     = 5;
  localparam int MAX_X2     = 5;
  localparam int MAX_X3     = 32;
  localparam int MAX_X4     = 32;
  localparam int MAX_Y1     = 32;
  localparam int MAX_Y2     = 32;
  localparam int MAX_M      = 1024;
  localparam int MAX_K      = 800;
  localparam int MAX_N      = 32;

  localparam int LAYER_W = $clog2(MAX_LAYERS);
  localparam int NUM_W   = LAYER_W + 1;
  localparam int X1_W    = $clog2(MAX_X1 + 1);
  localparam int X2_W    = $clog2(MAX_X2 + 1);
  localparam int X3_W    = $clog2(MAX_X3 + 1);
  localparam int X4_W    = $clog2(MAX_X4 + 1);
  localparam int Y1_W    = $clog2(MAX_Y1 + 1);
  localparam int Y2_W    = $clog2(MAX_Y2 + 1);
  localparam int M_W     = $clog2(MAX_M) + 1;
  localparam int N_W     = $clog2(MAX_N) + 1;
  localparam int K_W     = $clog2(MAX_K) + 1;

  typedef struct packed {
    logic [X1_W-1:0] x1;
    logic [X2_W-1:0] x2;
    logic [X3_W-1:0] x3;
    logic [X4_W-1:0] x4;
    logic [Y1_W-1:0] y1;
    logic [Y2_W-1:0] y2;
    logic [1:0]      stride_base;
    logic [1:0]      pad_next;
  } layer_desc_t;

  localparam int DESC_W = $bits(layer_desc_t);

  // Only the input geometry of the following layer is needed downstream.
  typedef struct packed {
    logic [Y1_W-1:0] y1;
    logic [Y2_W-1:0] y2;
    logic [X3_W-1:0] y3;
  } next_geom_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, CALC1, CALC2, ISSUE, RUN, FINISH
  } seq_state_t;

  // Output extent along one axis for a valid (X <= Y) window and stride 2^S.
  function automatic logic [M_W-1:0] calc_out_dim(input logic [Y1_W-1:0] y,
                                                  input logic [Y1_W-1:0] x,
                                                  input logic [1:0]      s);
    logic [Y1_W-1:0] span;
    span = (y - x) >> s;
    return M_W'(span) + M_W'(1);
  endfunction

endpackage

// File: rtl/cnn_desc_ram.sv
// Descriptor table: one write port, two registered read ports.
// Port 0 returns the full current-layer descriptor, port 1 only the
// input geometry of the following layer. Contents are not reset.
module cnn_desc_ram
  import cnn_seq_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [LAYER_W-1:0] waddr,
  input  layer_desc_t        wdata,
  input  logic [LAYER_W-1:0] raddr0,
  input  logic [LAYER_W-1:0] raddr1,
  output layer_desc_t        rdata0,
  output next_geom_t         rdata1
);

  layer_desc_t mem [MAX_LAYERS];

  // Synchronous write and registered dual read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata0    <= mem[raddr0];
    rdata1.y1 <= mem[raddr1].y1;
    rdata1.y2 <= mem[raddr1].y2;
    rdata1.y3 <= mem[raddr1].x3;
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Network-level sequencer: walks a runtime-loaded descriptor table, derives
// GEMM dimensions per layer in registered stages and hands each layer to the
// compute engine with a layer_start / layer_done handshake.
// Optional macro LAYER_PERF_CNT_EN adds per-layer and per-run cycle counters.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_addr,
  input  logic [DESC_W-1:0]  cfg_wdata,
  input  logic [NUM_W-1:0]   cfg_num_layers,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic [LAYER_W-1:0] layer,
  output logic [X1_W-1:0]    X1,
  output logic [X2_W-1:0]    X2,
  output logic [X3_W-1:0]    X3,
  output logic [X4_W-1:0]    X4,
  output logic [Y1_W-1:0]    Y1,
  output logic [Y2_W-1:0]    Y2,
  output logic [X3_W-1:0]    Y3,
  output logic [Y1_W-1:0]    next_Y1,
  output logic [Y2_W-1:0]    next_Y2,
  output logic [X3_W-1:0]    next_Y3,
  output logic [2:0]         STRIDE,
  output logic [M_W-1:0]     M,
  output logic [M_W-1:0]     Mij,
  output logic [M_W-1:0]     padding_M,
  output logic [N_W-1:0]     N,
  output logic [K_W-1:0]     K,
  output logic               layer_start,
  input  logic               layer_done,
  output logic               net_done,
  output logic               cfg_err
`ifdef LAYER_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_last,
  output logic [31:0]        perf_total
`endif
);

  seq_state_t         state, state_nxt;
  logic [NUM_W-1:0]   num_layers;
  layer_desc_t        cur_desc;
  next_geom_t         nxt_geom;
  logic [M_W-1:0]     mij_p1, mj_p1;
  logic               num_ok, start_ok, last_layer, done_ok, desc_bad, ram_we;

  assign num_ok     = (cfg_num_layers != '0) && (cfg_num_layers <= NUM_W'(MAX_LAYERS));
  assign start_ok   = (state == IDLE) && start && !abort;
  assign last_layer = ({1'b0, layer} == (num_layers - NUM_W'(1)));
  // A done that lands in the layer_start cycle belongs to no issued layer.
  assign done_ok    = (state == RUN) && layer_done && !layer_start;
  assign ram_we     = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < NUM_W'(MAX_LAYERS));

  assign desc_bad = (cur_desc.x1 == '0) || (cur_desc.x2 == '0) ||
                    (cur_desc.x3 == '0) || (cur_desc.x4 == '0) ||
                    (cur_desc.y1 == '0) || (cur_desc.y2 == '0) ||
                    (Y1_W'(cur_desc.x1) > cur_desc.y1) ||
                    (Y2_W'(cur_desc.x2) > cur_desc.y2) ||
                    (cur_desc.stride_base == 2'd3);

  cnn_desc_ram u_desc_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (cfg_addr),
    .wdata  (layer_desc_t'(cfg_wdata)),
    .raddr0 (layer),
    .raddr1 (layer + LAYER_W'(1)),
    .rdata0 (cur_desc),
    .rdata1 (nxt_geom)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and state-derived status outputs; abort wins over all.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    net_done  = (state == FINISH);
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && num_ok) state_nxt = FETCH;
        FETCH:   state_nxt = CALC1;
        CALC1:   state_nxt = desc_bad ? FINISH : CALC2;
        CALC2:   state_nxt = ISSUE;
        ISSUE:   state_nxt = RUN;
        RUN:     if (done_ok) state_nxt = last_layer ? FINISH : FETCH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Run control: layer index, sampled layer count, error flag, start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer       <= '0;
      num_layers  <= '0;
      cfg_err     <= 1'b0;
      layer_start <= 1'b0;
    end else begin
      layer_start <= (state == ISSUE) && !abort;
      if (abort) begin
        layer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (num_ok) begin
                num_layers <= cfg_num_layers;
                layer      <= '0;
                cfg_err    <= 1'b0;
              end else begin
                cfg_err    <= 1'b1;
              end
            end
          end
          CALC1:   if (desc_bad) cfg_err <= 1'b1;
          RUN:     if (done_ok && !last_layer) layer <= layer + LAYER_W'(1);
          FINISH:  layer <= '0;
          default: ;
        endcase
      end
    end
  end

  // Stage 1: per-axis output extents from the fetched descriptor.
  always_ff @(posedge clk) begin
    if (state == CALC1) begin
      mij_p1 <= calc_out_dim(cur_desc.y1, Y1_W'(cur_desc.x1), cur_desc.stride_base);
      mj_p1  <= calc_out_dim(cur_desc.y2, Y2_W'(cur_desc.x2), cur_desc.stride_base);
    end
  end

  // Stage 2: publish geometry; held untouched until the next layer's CALC2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      X1 <= '0; X2 <= '0; X3 <= '0; X4 <= '0;
      Y1 <= '0; Y2 <= '0; Y3 <= '0;
      next_Y1 <= '0; next_Y2 <= '0; next_Y3 <= '0;
      STRIDE <= '0; M <= '0; Mij <= '0; padding_M <= '0; N <= '0; K <= '0;
    end else if ((state == CALC2) && !abort) begin
      X1        <= cur_desc.x1;
      X2        <= cur_desc.x2;
      X3        <= cur_desc.x3;
      X4        <= cur_desc.x4;
      Y1        <= cur_desc.y1;
      Y2        <= cur_desc.y2;
      Y3        <= cur_desc.x3;
      next_Y1   <= last_layer ? '0 : nxt_geom.y1;
      next_Y2   <= last_layer ? '0 : nxt_geom.y2;
      next_Y3   <= last_layer ? '0 : nxt_geom.y3;
      STRIDE    <= 3'b001 << cur_desc.stride_base;
      Mij       <= mij_p1;
      M         <= mij_p1 * mj_p1;
      padding_M <= (mij_p1 + M_W'(cur_desc.pad_next)) * (mj_p1 + M_W'(cur_desc.pad_next));
      N         <= N_W'(cur_desc.x4);
      K         <= K_W'(cur_desc.x1) * K_W'(cur_desc.x2) * K_W'(cur_desc.x3);
    end
  end

`ifdef LAYER_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // RUN-cycle counters; the done cycle itself is counted in perf_last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_last   <= '0;
      perf_total  <= '0;
    end else begin
      if (start_ok && num_ok)  perf_total <= '0;
      else if (state == RUN)   perf_total <= sat_inc(perf_total);
      if (state == ISSUE)      perf_cycles <= '0;
      else if (state == RUN)   perf_cycles <= sat_inc(perf_cycles);
      if (done_ok && !abort)   perf_last <= sat_inc(perf_cycles);
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed plus randomized bench for cnn_layer_sequencer. Expected geometry
// is computed from descriptor fields with integer arithmetic held in a small
// table model; timing expectations come from the handshake latencies.
module tb_cnn_layer_sequencer;
  import cnn_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [LAYER_W-1:0] cfg_addr;
  logic [DESC_W-1:0]  cfg_wdata;
  logic [NUM_W-1:0]   cfg_num_layers;
  logic               start, abort, layer_done;
  logic               busy, layer_start, net_done, cfg_err;
  logic [LAYER_W-1:0] layer;
  logic [X1_W-1:0]    X1;
  logic [X2_W-1:0]    X2;
  logic [X3_W-1:0]    X3, Y3, next_Y3;
  logic [X4_W-1:0]    X4;
  logic [Y1_W-1:0]    Y1, next_Y1;
  logic [Y2_W-1:0]    Y2, next_Y2;
  logic [2:0]         STRIDE;
  logic [M_W-1:0]     M, Mij, padding_M;
  logic [N_W-1:0]     N;
  logic [K_W-1:0]     K;
`ifdef LAYER_PERF_CNT_EN
  logic [31:0]        perf_cycles, perf_last, perf_total;
`endif

  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num_layers(cfg_num_layers), .start(start), .abort(abort), .busy(busy),
    .layer(layer), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .next_Y1(next_Y1), .next_Y2(next_Y2), .next_Y3(next_Y3), .STRIDE(STRIDE),
    .M(M), .Mij(Mij), .padding_M(padding_M), .N(N), .K(K),
    .layer_start(layer_start), .layer_done(layer_done), .net_done(net_done),
    .cfg_err(cfg_err)
`ifdef LAYER_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_last(perf_last), .perf_total(perf_total)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mx1[MAX_LAYERS], mx2[MAX_LAYERS], mx3[MAX_LAYERS], mx4[MAX_LAYERS];
  int my1[MAX_LAYERS], my2[MAX_LAYERS], ms[MAX_LAYERS], mp[MAX_LAYERS];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_desc(input int a, input int x1, input int x2, input int x3,
                            input int x4, input int y1, input int y2, input int s,
                            input int p, input bit track);
    cfg_we    = 1'b1;
    cfg_addr  = LAYER_W'(a);
    cfg_wdata = {X1_W'(x1), X2_W'(x2), X3_W'(x3), X4_W'(x4),
                 Y1_W'(y1), Y2_W'(y2), 2'(s), 2'(p)};
    tick();
    cfg_we = 1'b0;
    if (track) begin
      mx1[a] = x1; mx2[a] = x2; mx3[a] = x3; mx4[a] = x4;
      my1[a] = y1; my2[a] = y2; ms[a] = s; mp[a] = p;
    end
  endtask

  task automatic rand_desc(input int a);
    int x1, x2;
    x1 = $urandom_range(1, 5);
    x2 = $urandom_range(1, 5);
    write_desc(a, x1, x2, $urandom_range(1, 32), $urandom_range(1, 32),
               $urandom_range(x1, 32), $urandom_range(x2, 32),
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
  endtask

  task automatic pulse_start(input int n);
    cfg_num_layers = NUM_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ls(input string tag, input int exp_lat);
    int c = 0;
    while (!layer_start && c < 20) begin
      tick();
      c++;
    end
    check(tag, c, exp_lat);
  endtask

  task automatic check_geom(input int i, input int n);
    int mij, mj, last;
    last = (i == n - 1);
    mij = (my1[i] - mx1[i]) / (1 << ms[i]) + 1;
    mj  = (my2[i] - mx2[i]) / (1 << ms[i]) + 1;
    check("layer", layer, i);
    check("X1", X1, mx1[i]);
    check("X2", X2, mx2[i]);
    check("X3", X3, mx3[i]);
    check("X4", X4, mx4[i]);
    check("Y1", Y1, my1[i]);
    check("Y2", Y2, my2[i]);
    check("Y3", Y3, mx3[i]);
    check("next_Y1", next_Y1, last ? 0 : my1[i+1]);
    check("next_Y2", next_Y2, last ? 0 : my2[i+1]);
    check("next_Y3", next_Y3, last ? 0 : mx3[i+1]);
    check("STRIDE", STRIDE, 1 << ms[i]);
    check("Mij", Mij, mij);
    check("M", M, mij * mj);
    check("padding_M", padding_M, (mij + mp[i]) * (mj + mp[i]));
    check("N", N, mx4[i]);
    check("K", K, mx1[i] * mx2[i] * mx3[i]);
  endtask

  task automatic run_net(input int n);
    pulse_start(n);
    check("err_clr", cfg_err, 0);
    for (int i = 0; i < n; i++) begin
      wait_ls($sformatf("lat_l%0d", i), 4);
      check_geom(i, n);
      repeat ($urandom_range(1, 4)) tick();
      check("hold_M", M, (((my1[i]-mx1[i])/(1<<ms[i]))+1) * (((my2[i]-mx2[i])/(1<<ms[i]))+1));
      layer_done = 1'b1;
      tick();
      layer_done = 1'b0;
      if (i == n - 1) begin
        check("net_done", net_done, 1);
        tick();
        check("net_done_end", net_done, 0);
        check("busy_end", busy, 0);
        check("layer_end", layer, 0);
      end
    end
  endtask

  initial begin
    int ls_seen, nd_seen;
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_num_layers = '0;
    start = 1'b0; abort = 1'b0; layer_done = 1'b0;
    tick(); tick();
    // reset state
    check("rst_busy", busy, 0);
    check("rst_layer", layer, 0);
    check("rst_ls", layer_start, 0);
    check("rst_nd", net_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_M", M, 0);
    check("rst_K", K, 0);
    rst = 1'b1;
    tick();

    // LeNet layer 0 then a stride-2 layer 1
    write_desc(0, 5, 5, 1, 6, 32, 32, 0, 1, 1'b1);
    write_desc(1, 3, 3, 6, 6, 29, 29, 1, 0, 1'b1);
    pulse_start(1);
    wait_ls("lenet_lat", 4);
    check("lenet_Mij", Mij, 28);
    check("lenet_M", M, 784);
    check("lenet_padM", padding_M, 841);
    check("lenet_K", K, 25);
    check("lenet_N", N, 6);
    check("lenet_STRIDE", STRIDE, 1);
    check("lenet_nY1", next_Y1, 0);
    check("lenet_nY2", next_Y2, 0);
    check("lenet_nY3", next_Y3, 0);
    // done coincident with layer_start must be ignored
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("coinc_busy", busy, 1);
    check("coinc_nd", net_done, 0);
    tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("lenet_nd", net_done, 1);
    tick();
    check("lenet_busy", busy, 0);

    pulse_start(2);
    wait_ls("two_lat0", 4);
    check("two_nY1", next_Y1, 29);
    check("two_nY3", next_Y3, 6);
    tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("two_nd_mid", net_done, 0);
    wait_ls("two_lat1", 4);
    check("two_layer", layer, 1);
    check("two_Mij", Mij, 14);
    check("two_M", M, 196);
    check("two_padM", padding_M, 196);
    check("two_K", K, 54);
    check("two_STRIDE", STRIDE, 2);
    check("two_nY1_last", next_Y1, 0);
    tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("two_nd", net_done, 1);
    tick();

    // invalid descriptor
    write_desc(0, 7, 3, 1, 1, 5, 5, 0, 0, 1'b0);
    pulse_start(1);
    ls_seen = 0; nd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      ls_seen += int'(layer_start);
      nd_seen += int'(net_done);
      tick();
    end
    check("bad_err", cfg_err, 1);
    check("bad_nd", nd_seen, 1);
    check("bad_ls", ls_seen, 0);
    check("bad_busy", busy, 0);
    write_desc(0, 5, 5, 1, 6, 32, 32, 0, 1, 1'b1);

    // invalid layer counts
    pulse_start(0);
    check("num0_busy", busy, 0);
    check("num0_err", cfg_err, 1);
    pulse_start(9);
    check("num9_busy", busy, 0);
    check("num9_err", cfg_err, 1);

    // randomized networks
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, MAX_LAYERS);
      for (int a = 0; a < n; a++) rand_desc(a);
      run_net(n);
    end

    // abort coincident with layer_done on layer 1 of 3
    for (int a = 0; a < 3; a++) rand_desc(a);
    pulse_start(3);
    wait_ls("ab_lat0", 4);
    tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    wait_ls("ab_lat1", 4);
    tick();
    layer_done = 1'b1;
    abort = 1'b1;
    tick();
    layer_done = 1'b0;
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_layer", layer, 0);
    check("ab_nd", net_done, 0);
    ls_seen = 0; nd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      ls_seen += int'(layer_start);
      nd_seen += int'(net_done);
    end
    check("ab_no_ls", ls_seen, 0);
    check("ab_no_nd", nd_seen, 0);

    // writes and start while busy are ignored
    pulse_start(1);
    wait_ls("bw_lat", 4);
    tick();
    write_desc(0, 1, 1, 2, 2, 3, 3, 1, 1, 1'b0);
    cfg_num_layers = NUM_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bw_busy", busy, 1);
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("bw_nd", net_done, 1);
    tick();
    run_net(1);

`ifdef LAYER_PERF_CNT_EN
    pulse_start(1);
    wait_ls("perf_lat", 4);
    repeat (99) tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("perf_last", perf_last, 100);
    check("perf_total", perf_total, 100);
    tick();
`endif

    // asynchronous reset mid-RUN
    pulse_start(1);
    wait_ls("rs_lat", 4);
    tick();
    #2 rst = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_layer", layer, 0);
    check("rs_ls", layer_start, 0);
    check("rs_X1", X1, 0);
    check("rs_Mij", Mij, 0);
    check("rs_M", M, 0);
    check("rs_K", K, 0);
    check("rs_nd", net_done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rs_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
